// File: rtl/pe_cfg_pkg.sv
// Shared types and constants for the PE configuration sequencer.
// Optional broadcast load is enabled by defining PE_CFG_BCAST_EN.
package pe_cfg_pkg;

    localparam int INST_W_DEF    = 48;
    localparam int CTX_DEPTH_DEF = 32;
    localparam int RUN_W         = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_RUN,
        S_DONE
    } state_t;

    // Word address of one context; the caller truncates to ADDR_W for the wrap.
    function automatic logic [31:0] calc_addr(input logic [31:0] base,
                                              input logic [31:0] pe,
                                              input logic [31:0] ctx,
                                              input logic [31:0] depth);
        return base + pe * depth + ctx;
    endfunction

endpackage

// File: rtl/pe_cfg_sequencer_if.sv
// Configuration-memory read port: single outstanding request, grant, then read data.
interface pe_cfg_sequencer_if
    import pe_cfg_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int INST_W = INST_W_DEF
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [INST_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/pe_cfg_run_timer.sv
// Loadable down-counter timing the RUN phase; zero flags the final run cycle.
module pe_cfg_run_timer
    import pe_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [RUN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [RUN_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - RUN_W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/pe_cfg_sequencer.sv
// Loads per-PE contexts from config memory over the shared bus, then runs the array.
// Define PE_CFG_BCAST_EN to add the bcast input (one context image written to all PEs).
//   state | meaning
//   IDLE  | waiting for start; illegal num_ctx pulses err
//   CLR   | pe_rst pulse so PE write pointers restart at 0
//   FETCH | mem_req held until mem_gnt
//   WAIT  | waiting for mem_rvalid
//   WRITE | pe_inst/pe_init strobe for one cycle, advance indices
//   RUN   | pe_run held for run_cycles cycles
//   DONE  | done pulse
module pe_cfg_sequencer
    import pe_cfg_pkg::*;
#(
    parameter int NUM_PE    = 16,
    parameter int INST_W    = INST_W_DEF,
    parameter int CTX_DEPTH = CTX_DEPTH_DEF,
    parameter int ADDR_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
`ifdef PE_CFG_BCAST_EN
    input  logic               bcast,
`endif
    input  logic [5:0]         num_ctx,
    input  logic [RUN_W-1:0]   run_cycles,
    input  logic [ADDR_W-1:0]  cfg_base,
    pe_cfg_sequencer_if.master mem,
    output logic [INST_W-1:0]  pe_inst,
    output logic [NUM_PE-1:0]  pe_init,
    output logic               pe_run,
    output logic               pe_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_t            state, state_nxt;
    logic [PE_W-1:0]   pe_idx, pe_nxt;
    logic [5:0]        ctx_idx, ctx_nxt, num_ctx_q;
    logic [RUN_W-1:0]  run_cycles_q;
    logic [ADDR_W-1:0] cfg_base_q, mem_addr_q, addr_nxt;
    logic [NUM_PE-1:0] init_mask;
    logic              mem_req_q, latch, err_nxt, load_timer, dec_timer, timer_zero;
    logic              bcast_q, start_bad, last_ctx, last_pe;

    assign start_bad = (num_ctx == 6'd0) || (32'(num_ctx) > 32'(CTX_DEPTH));
    assign last_ctx  = (ctx_idx == num_ctx_q - 6'd1);
    assign last_pe   = bcast_q || (pe_idx == PE_W'(NUM_PE - 1));
    assign addr_nxt  = ADDR_W'(calc_addr(32'(cfg_base_q), bcast_q ? 32'd0 : 32'(pe_nxt),
                                         32'(ctx_nxt), 32'(CTX_DEPTH)));

`ifdef PE_CFG_BCAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        bcast_q <= 1'b0;
        else if (latch) bcast_q <= bcast;
    end
`else
    assign bcast_q = 1'b0;
`endif

    always_comb begin
        init_mask = '0;
        if (bcast_q) init_mask = '1;
        else         init_mask[pe_idx] = 1'b1;
    end

    pe_cfg_run_timer u_run_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_timer),
        .load_val (run_cycles_q - RUN_W'(1)),
        .dec      (dec_timer),
        .zero     (timer_zero)
    );

    always_comb begin
        state_nxt  = state;
        pe_nxt     = pe_idx;
        ctx_nxt    = ctx_idx;
        latch      = 1'b0;
        err_nxt    = 1'b0;
        load_timer = 1'b0;
        dec_timer  = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                if (start_bad) err_nxt = 1'b1;
                else begin
                    latch     = 1'b1;
                    pe_nxt    = '0;
                    ctx_nxt   = '0;
                    state_nxt = S_CLR;
                end
            end
            S_CLR:   state_nxt = S_FETCH;
            S_FETCH: if (mem.mem_gnt)    state_nxt = S_WAIT;
            S_WAIT:  if (mem.mem_rvalid) state_nxt = S_WRITE;
            S_WRITE: begin
                state_nxt = S_FETCH;
                if (!last_ctx)
                    ctx_nxt = ctx_idx + 6'd1;
                else begin
                    ctx_nxt = '0;
                    if (!last_pe)
                        pe_nxt = pe_idx + PE_W'(1);
                    else begin
                        load_timer = 1'b1;
                        state_nxt  = (run_cycles_q == '0) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: if (timer_zero) state_nxt = S_DONE; else dec_timer = 1'b1;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt  = S_IDLE;
            load_timer = 1'b0;
            dec_timer  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_idx       <= '0;
            ctx_idx      <= '0;
            num_ctx_q    <= '0;
            run_cycles_q <= '0;
            cfg_base_q   <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            pe_inst      <= '0;
            pe_init      <= '0;
            pe_run       <= 1'b0;
            pe_rst       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (latch) begin
                num_ctx_q    <= num_ctx;
                run_cycles_q <= run_cycles;
                cfg_base_q   <= cfg_base;
            end
            pe_idx    <= pe_nxt;
            ctx_idx   <= ctx_nxt;
            if (state_nxt == S_FETCH) mem_addr_q <= addr_nxt;
            if (state == S_WAIT && state_nxt == S_WRITE) pe_inst <= mem.mem_rdata;
            mem_req_q <= (state_nxt == S_FETCH);
            pe_init   <= (state_nxt == S_WRITE) ? init_mask : '0;
            pe_run    <= (state_nxt == S_RUN);
            pe_rst    <= (state_nxt == S_CLR);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
            err       <= err_nxt;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// Scoreboard bench for pe_cfg_sequencer with NUM_PE=4 and a reactive memory model.
module tb_pe_cfg_sequencer;
    typedef struct packed {
        logic [3:0]  init;
        logic [47:0] inst;
    } wr_t;

    localparam logic [11:0] ADDR_A [8] = '{12'h100, 12'h101, 12'h120, 12'h121, 12'h140, 12'h141, 12'h160, 12'h161};
    localparam logic [11:0] ADDR_W [8] = '{12'hFC0, 12'hFC1, 12'hFE0, 12'hFE1, 12'h000, 12'h001, 12'h020, 12'h021};
    localparam logic [3:0]  INIT_2 [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    localparam logic [11:0] ADDR_Z [4] = '{12'h010, 12'h030, 12'h050, 12'h070};
    localparam logic [11:0] ADDR_P [4] = '{12'h300, 12'h320, 12'h340, 12'h360};
    localparam logic [11:0] ADDR_R [4] = '{12'h500, 12'h520, 12'h540, 12'h560};
    localparam logic [3:0]  INIT_1 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    logic        clk, rst, start, abort;
    logic [5:0]  num_ctx;
    logic [15:0] run_cycles;
    logic [11:0] cfg_base;
    logic [47:0] pe_inst;
    logic [3:0]  pe_init;
    logic        pe_run, pe_rst, busy, done, err;
`ifdef PE_CFG_BCAST_EN
    logic        bcast;
`endif

    int  checks = 0, failures = 0;
    int  gnt_stall = 0, lat_fixed = 1;
    bit  lat_vary = 0;
    logic [11:0] exp_addr_q [$];
    wr_t         exp_w_q [$];

    pe_cfg_sequencer_if #(.ADDR_W(12), .INST_W(48)) mem ();

    pe_cfg_sequencer #(.NUM_PE(4), .INST_W(48), .CTX_DEPTH(32), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef PE_CFG_BCAST_EN
        .bcast(bcast),
`endif
        .num_ctx(num_ctx), .run_cycles(run_cycles), .cfg_base(cfg_base), .mem(mem),
        .pe_inst(pe_inst), .pe_init(pe_init), .pe_run(pe_run), .pe_rst(pe_rst),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] mdata(input logic [11:0] a);
        return {12'hA5C, a, 12'h3E1, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [3:0] i);
        exp_addr_q.push_back(a);
        exp_w_q.push_back('{init: i, inst: mdata(a)});
    endtask

    // Memory model: reacts just after each rising edge, one request in flight.
    initial begin
        int stall_n, lat_n, nreq;
        logic [11:0] paddr;
        stall_n = 0; lat_n = 0; nreq = 0; paddr = '0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
            if (rst) begin
                stall_n = 0; lat_n = 0;
            end else if (lat_n > 0) begin
                lat_n--;
                if (lat_n == 0) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata  = mdata(paddr);
                end
            end else if (mem.mem_req) begin
                if (stall_n < gnt_stall) stall_n++;
                else begin
                    mem.mem_gnt = 1'b1;
                    stall_n = 0;
                    paddr = mem.mem_addr;
                    lat_n = lat_vary ? 1 + (nreq % 4) : lat_fixed;
                    nreq++;
                end
            end else stall_n = 0;
        end
    end

    // Monitor: pops the scoreboard on every accepted request and every PE write.
    initial begin
        logic        prev_hold;
        logic [11:0] prev_addr;
        wr_t         w;
        prev_hold = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_hold && mem.mem_req) check("addr_stable", 64'(mem.mem_addr), 64'(prev_addr));
                if (mem.mem_req && mem.mem_gnt) begin
                    if (exp_addr_q.size() == 0) check("unexpected_req", 64'(mem.mem_addr), 64'hFFFF);
                    else check("req_addr", 64'(mem.mem_addr), 64'(exp_addr_q.pop_front()));
                end
                prev_hold = mem.mem_req && !mem.mem_gnt;
                prev_addr = mem.mem_addr;
                if (pe_init != 4'd0) begin
                    if (exp_w_q.size() == 0) check("unexpected_init", 64'(pe_init), 64'(0));
                    else begin
                        w = exp_w_q.pop_front();
                        check("pe_init", 64'(pe_init), 64'(w.init));
                        check("pe_inst", 64'(pe_inst), 64'(w.inst));
                    end
                end
            end else prev_hold = 1'b0;
        end
    end

    task automatic pulse_start(input logic [5:0] nc, input logic [15:0] rc, input logic [11:0] base);
        num_ctx = nc; run_cycles = rc; cfg_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input logic [5:0] nc, input logic [15:0] rc, input logic [11:0] base);
        int  last_init, done_at, run_n, rst_n, run_first;
        bit  fin;
        pulse_start(nc, rc, base);
        check("start_pe_rst", 64'(pe_rst), 64'(1));
        check("start_busy", 64'(busy), 64'(1));
        last_init = -1; done_at = -1; run_n = 0; rst_n = 1; run_first = -1; fin = 0;
        for (int k = 1; k < 4000 && !fin; k++) begin
            @(negedge clk);
            if (pe_rst) rst_n++;
            if (pe_init != 4'd0) last_init = k;
            if (pe_run) begin
                run_n++;
                if (run_first < 0) run_first = k;
            end
            if (done) begin done_at = k; fin = 1; end
        end
        check("job_done_seen", 64'(fin), 64'(1));
        check("pe_rst_cycles", 64'(rst_n), 64'(1));
        check("pe_run_cycles", 64'(run_n), 64'(rc));
        check("done_after_write", 64'(done_at - last_init), 64'(int'(rc) + 1));
        if (rc != 16'd0) check("run_after_write", 64'(run_first - last_init), 64'(1));
        @(negedge clk);
        check("idle_after_done", 64'({busy, done, pe_run}), 64'(0));
        check("writes_left", 64'(exp_w_q.size()), 64'(0));
        check("reads_left", 64'(exp_addr_q.size()), 64'(0));
    endtask

    task automatic err_test(input logic [5:0] nc);
        int e, q;
        e = 0; q = 0;
        pulse_start(nc, 16'd3, 12'h100);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (err) e++;
            if (busy || pe_rst || mem.mem_req) q++;
        end
        check("err_cycles", 64'(e), 64'(1));
        check("err_quiet", 64'(q), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  got, bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_ctx = 6'd1; run_cycles = '0; cfg_base = '0;
`ifdef PE_CFG_BCAST_EN
        bcast = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({busy, done, err, pe_run, pe_rst, mem.mem_req}), 64'(0));
        check("rst_init", 64'(pe_init), 64'(0));
        check("rst_inst", 64'(pe_inst), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) push(ADDR_A[i], INIT_2[i]);
        run_job(6'd2, 16'd5, 12'h100);

        err_test(6'd0);
        err_test(6'd33);

        gnt_stall = 3; lat_vary = 1;
        for (int i = 0; i < 8; i++) push(ADDR_W[i], INIT_2[i]);
        run_job(6'd2, 16'd2, 12'hFC0);
        gnt_stall = 0; lat_vary = 0; lat_fixed = 1;

        for (int i = 0; i < 4; i++) push(ADDR_Z[i], INIT_1[i]);
        run_job(6'd1, 16'd0, 12'h010);

        // Abort in the first WAIT cycle; the read data arrives two cycles later.
        lat_fixed = 3;
        exp_addr_q.push_back(12'h200);
        pulse_start(6'd2, 16'd4, 12'h200);
        got = 0;
        for (int k = 0; k < 50 && got == 0; k++) begin
            @(negedge clk);
            if (mem.mem_req && mem.mem_gnt) got = 1;
        end
        check("abort_grant_seen", 64'(got), 64'(1));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 64'({busy, mem.mem_req, pe_run}), 64'(0));
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pe_init != 4'd0 || done || busy) bad++;
        end
        check("abort_quiet", 64'(bad), 64'(0));
        check("abort_reads_left", 64'(exp_addr_q.size()), 64'(0));
        lat_fixed = 1;
        for (int i = 0; i < 4; i++) push(ADDR_P[i], INIT_1[i]);
        run_job(6'd1, 16'd1, 12'h300);

        // Reset in the middle of a job.
        for (int i = 0; i < 4; i++) push(ADDR_R[i], INIT_1[i]);
        pulse_start(6'd1, 16'd3, 12'h500);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", 64'({busy, done, pe_run, pe_rst, mem.mem_req, pe_init}), 64'(0));
        check("midrst_inst", 64'(pe_inst), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_w_q.delete();
        @(negedge clk);

`ifdef PE_CFG_BCAST_EN
        bcast = 1'b1;
        for (int i = 0; i < 3; i++) push(12'h040 + 12'(i), 4'b1111);
        run_job(6'd3, 16'd3, 12'h040);
        bcast = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
